// File: rtl/dadda_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Dadda-style reducer.
package dadda_pkg;

  localparam int unsigned MAX_OPERANDS = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned full_width(input int unsigned input_width,
                                             input int unsigned num_operands,
                                             input int unsigned shift_step);
    return input_width + (num_operands - 1) * shift_step + clog2(num_operands);
  endfunction

  // Each 3:2 level turns every full group of three vectors into two.
  function automatic int unsigned tree_levels(input int unsigned num_operands);
    int unsigned n;
    int unsigned lvl;
    n = num_operands;
    lvl = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      lvl++;
    end
    return lvl;
  endfunction

  function automatic int unsigned level_count(input int unsigned num_operands,
                                              input int unsigned level);
    int unsigned n;
    n = num_operands;
    for (int unsigned i = 0; i < level; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int unsigned level_offset(input int unsigned num_operands,
                                               input int unsigned level);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < level; i++) begin
      off += level_count(num_operands, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/dadda_pipe_reducer_if.sv
// Handshake bundle for dadda_pipe_reducer; out_sum exists only with DADDA_FINAL_ADD_EN.
interface dadda_pipe_reducer_if #(
  parameter int unsigned InputWidth  = 8,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned OutputWidth = 12,
  parameter int unsigned TagWidth    = 4
);

  logic                              in_valid;
  logic                              in_ready;
  logic [NumOperands*InputWidth-1:0] in_operands;
  logic [TagWidth-1:0]               in_tag;
  logic                              out_valid;
  logic                              out_ready;
  logic [OutputWidth-1:0]            out_vector0;
  logic [OutputWidth-1:0]            out_vector1;
  logic [TagWidth-1:0]               out_tag;
`ifdef DADDA_FINAL_ADD_EN
  logic [OutputWidth-1:0]            out_sum;

  modport master (
    output in_valid, in_operands, in_tag, out_ready,
    input  in_ready, out_valid, out_vector0, out_vector1, out_tag, out_sum
  );

  modport slave (
    input  in_valid, in_operands, in_tag, out_ready,
    output in_ready, out_valid, out_vector0, out_vector1, out_tag, out_sum
  );
`else
  modport master (
    output in_valid, in_operands, in_tag, out_ready,
    input  in_ready, out_valid, out_vector0, out_vector1, out_tag
  );

  modport slave (
    input  in_valid, in_operands, in_tag, out_ready,
    output in_ready, out_valid, out_vector0, out_vector1, out_tag
  );
`endif

endinterface

// File: rtl/csa_row.sv
// Word-level 3:2 compressor: bitwise full adders, carry vector pre-shifted left by one.
module csa_row #(
  parameter int unsigned Width = 12
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] c,
  output logic [Width-1:0] sum,
  output logic [Width-1:0] carry
);

  logic [Width-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  // The carry out of the top column falls off: results are modulo 2^Width.
  assign carry = maj << 1;

endmodule

// File: rtl/dadda_pipe_reducer.sv
// Pipelined multi-operand reducer: operand register, 3:2 tree, carry-save register and,
// with DADDA_FINAL_ADD_EN defined, a registered carry-propagate stage.
module dadda_pipe_reducer
  import dadda_pkg::*;
#(
  parameter int unsigned InputWidth  = 8,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned ShiftStep   = 2,
  parameter int unsigned OutputWidth = 12,
  parameter int unsigned TagWidth    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  dadda_pipe_reducer_if.slave bus
);

  localparam int unsigned Levels = tree_levels(NumOperands);
  localparam int unsigned Total  = level_offset(NumOperands, Levels + 1);
  localparam int unsigned Last   = level_offset(NumOperands, Levels);

  if (NumOperands < 2 || NumOperands > MAX_OPERANDS) begin : g_bad_cfg
    $error("dadda_pipe_reducer: NumOperands must be within 2..8");
  end

  logic                              a_valid_q;
  logic [NumOperands*InputWidth-1:0] a_ops_q;
  logic [TagWidth-1:0]               a_tag_q;
  logic                              b_valid_q;
  logic [OutputWidth-1:0]            b_vec0_q;
  logic [OutputWidth-1:0]            b_vec1_q;
  logic [TagWidth-1:0]               b_tag_q;
  logic                              in_fire;
  logic                              a_advance;
  logic                              b_leave;

  // All tree vectors, level by level; level l starts at level_offset(NumOperands, l).
  logic [OutputWidth-1:0] node [Total];

  for (genvar k = 0; k < NumOperands; k++) begin : g_operand
    assign node[k] = OutputWidth'(a_ops_q[k*InputWidth +: InputWidth]) << (k * ShiftStep);
  end

  for (genvar l = 1; l <= Levels; l++) begin : g_level
    localparam int unsigned Prev    = level_count(NumOperands, l - 1);
    localparam int unsigned PrevOff = level_offset(NumOperands, l - 1);
    localparam int unsigned Off     = level_offset(NumOperands, l);
    localparam int unsigned Groups  = Prev / 3;

    for (genvar g = 0; g < Groups; g++) begin : g_row
      csa_row #(
        .Width(OutputWidth)
      ) u_csa_row (
        .a    (node[PrevOff + 3*g]),
        .b    (node[PrevOff + 3*g + 1]),
        .c    (node[PrevOff + 3*g + 2]),
        .sum  (node[Off + 2*g]),
        .carry(node[Off + 2*g + 1])
      );
    end

    for (genvar r = 0; r < Prev % 3; r++) begin : g_pass
      assign node[Off + 2*Groups + r] = node[PrevOff + 3*Groups + r];
    end
  end

`ifdef DADDA_FINAL_ADD_EN
  logic                   c_valid_q;
  logic [OutputWidth-1:0] c_vec0_q;
  logic [OutputWidth-1:0] c_vec1_q;
  logic [OutputWidth-1:0] c_sum_q;
  logic [TagWidth-1:0]    c_tag_q;
  logic                   c_load;

  assign c_load  = !c_valid_q || bus.out_ready;
  assign b_leave = b_valid_q && c_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_vec0_q  <= '0;
      c_vec1_q  <= '0;
      c_sum_q   <= '0;
      c_tag_q   <= '0;
    end else begin
      if (c_load) c_valid_q <= b_valid_q;
      if (b_leave) begin
        c_vec0_q <= b_vec0_q;
        c_vec1_q <= b_vec1_q;
        c_sum_q  <= b_vec0_q + b_vec1_q;
        c_tag_q  <= b_tag_q;
      end
    end
  end

  assign bus.out_valid   = c_valid_q;
  assign bus.out_vector0 = c_vec0_q;
  assign bus.out_vector1 = c_vec1_q;
  assign bus.out_sum     = c_sum_q;
  assign bus.out_tag     = c_tag_q;
`else
  assign b_leave = b_valid_q && bus.out_ready;

  assign bus.out_valid   = b_valid_q;
  assign bus.out_vector0 = b_vec0_q;
  assign bus.out_vector1 = b_vec1_q;
  assign bus.out_tag     = b_tag_q;
`endif

  assign a_advance    = !b_valid_q || b_leave;
  assign bus.in_ready = !a_valid_q || a_advance;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_ops_q   <= '0;
      a_tag_q   <= '0;
    end else begin
      if (bus.in_ready) a_valid_q <= bus.in_valid;
      if (in_fire) begin
        a_ops_q <= bus.in_operands;
        a_tag_q <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      b_vec0_q  <= '0;
      b_vec1_q  <= '0;
      b_tag_q   <= '0;
    end else begin
      if (a_advance) b_valid_q <= a_valid_q;
      if (a_advance && a_valid_q) begin
        b_vec0_q <= node[Last];
        b_vec1_q <= node[Last + 1];
        b_tag_q  <= a_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_dadda_pipe_reducer.sv
// Directed self-checking bench for dadda_pipe_reducer (default, 13-bit and wide configs).
module tb_dadda_pipe_reducer;
  import dadda_pkg::*;

  localparam int unsigned WOw = full_width(16, 8, 1);
`ifdef DADDA_FINAL_ADD_EN
  localparam int Depth = 3;
`else
  localparam int Depth = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dadda_pipe_reducer_if #(.InputWidth(8), .NumOperands(3), .OutputWidth(12), .TagWidth(4))
    bus0 ();
  dadda_pipe_reducer_if #(.InputWidth(8), .NumOperands(3), .OutputWidth(13), .TagWidth(4))
    bus13 ();
  dadda_pipe_reducer_if #(.InputWidth(16), .NumOperands(8), .OutputWidth(WOw), .TagWidth(4))
    busw ();

  dadda_pipe_reducer #(
    .InputWidth(8), .NumOperands(3), .ShiftStep(2), .OutputWidth(12), .TagWidth(4)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  dadda_pipe_reducer #(
    .InputWidth(8), .NumOperands(3), .ShiftStep(2), .OutputWidth(13), .TagWidth(4)
  ) u_dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

  dadda_pipe_reducer #(
    .InputWidth(16), .NumOperands(8), .ShiftStep(1), .OutputWidth(WOw), .TagWidth(4)
  ) u_dutw (.clk(clk), .rst_n(rst_n), .bus(busw));

  function automatic logic [11:0] model0(input logic [23:0] ops);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < 3; k++) acc += 32'(ops[k*8 +: 8]) << (2 * k);
    return acc[11:0];
  endfunction

  function automatic logic [WOw-1:0] modelw(input logic [127:0] ops);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) acc += 64'(ops[k*16 +: 16]) << k;
    return acc[WOw-1:0];
  endfunction

  function automatic logic [11:0] sum0();
    return bus0.out_vector0 + bus0.out_vector1;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %0b want 1", bus0.in_ready); end
    checks++; if (bus0.out_vector0 !== 12'h0 || bus0.out_vector1 !== 12'h0) begin errors++;
      $display("FAIL reset_vectors got %0h/%0h want 0/0", bus0.out_vector0, bus0.out_vector1); end
    checks++; if (bus0.out_tag !== 4'h0) begin errors++;
      $display("FAIL reset_tag got %0h want 0", bus0.out_tag); end
`ifdef DADDA_FINAL_ADD_EN
    checks++; if (bus0.out_sum !== 12'h0) begin errors++;
      $display("FAIL reset_sum got %0h want 0", bus0.out_sum); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL post_reset got ready=%0b valid=%0b want 1/0", bus0.in_ready, bus0.out_valid);
    end
  endtask

  task automatic test_ones();
    bus0.out_ready   = 1'b1;
    bus0.in_operands = {3{8'h01}};
    bus0.in_tag      = 4'h5;
    bus0.in_valid    = 1'b1;
    checks++; if (bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL ones_in_ready got %0b want 1", bus0.in_ready); end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL ones_early_valid got %0b want 0", bus0.out_valid); end
    repeat (Depth - 1) @(posedge clk);
    #1;
    checks++; if (bus0.out_valid !== 1'b1) begin errors++;
      $display("FAIL ones_valid got %0b want 1", bus0.out_valid); end
    checks++; if (sum0() !== 12'h015) begin errors++;
      $display("FAIL ones_sum got %0h want 015", sum0()); end
    checks++; if (bus0.out_tag !== 4'h5) begin errors++;
      $display("FAIL ones_tag got %0h want 5", bus0.out_tag); end
`ifdef DADDA_FINAL_ADD_EN
    checks++; if (bus0.out_sum !== 12'h015) begin errors++;
      $display("FAIL ones_out_sum got %0h want 015", bus0.out_sum); end
`endif
    @(posedge clk); #1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL ones_drained got %0b want 0", bus0.out_valid); end
  endtask

  task automatic test_saturated();
    logic [12:0] s13;
    bus0.in_operands  = {3{8'hFF}};
    bus0.in_tag       = 4'hA;
    bus0.in_valid     = 1'b1;
    bus13.in_operands = {3{8'hFF}};
    bus13.in_tag      = 4'hB;
    bus13.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid  = 1'b0;
    bus13.in_valid = 1'b0;
    repeat (Depth - 1) @(posedge clk);
    #1;
    s13 = bus13.out_vector0 + bus13.out_vector1;
    checks++; if (bus0.out_valid !== 1'b1 || sum0() !== 12'h4EB) begin errors++;
      $display("FAIL ff_sum12 got v=%0b %0h want 1 4eb", bus0.out_valid, sum0()); end
    checks++; if (bus0.out_tag !== 4'hA) begin errors++;
      $display("FAIL ff_tag12 got %0h want a", bus0.out_tag); end
    checks++; if (bus13.out_valid !== 1'b1 || s13 !== 13'h14EB) begin errors++;
      $display("FAIL ff_sum13 got v=%0b %0h want 1 14eb", bus13.out_valid, s13); end
`ifdef DADDA_FINAL_ADD_EN
    checks++; if (bus0.out_sum !== 12'h4EB) begin errors++;
      $display("FAIL ff_out_sum got %0h want 4eb", bus0.out_sum); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [23:0] ops [8];
    int j;
    for (int i = 0; i < 8; i++) ops[i] = 24'($urandom);
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 8 + Depth - 1; c++) begin
      if (c < 8) begin
        bus0.in_valid    = 1'b1;
        bus0.in_operands = ops[c];
        bus0.in_tag      = 4'(c);
        checks++; if (bus0.in_ready !== 1'b1) begin errors++;
          $display("FAIL b2b_in_ready cycle %0d got %0b want 1", c, bus0.in_ready); end
      end else begin
        bus0.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= Depth - 1) begin
        j = c - (Depth - 1);
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_tag !== 4'(j) || sum0() !== model0(ops[j]))
        begin
          errors++;
          $display("FAIL b2b_result %0d got v=%0b tag=%0h sum=%0h want 1 %0h %0h", j,
                   bus0.out_valid, bus0.out_tag, sum0(), j, model0(ops[j]));
        end
      end
    end
    @(posedge clk); #1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_tail got %0b want 0", bus0.out_valid); end
  endtask

  task automatic test_stall();
    logic [23:0]      ops [4];
    logic [11:0]      r0, r1;
    logic [3:0]       rt;
    logic             fire;
    int               acc;
    for (int i = 0; i < 4; i++) ops[i] = 24'($urandom);
    bus0.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      bus0.in_valid    = 1'b1;
      bus0.in_operands = ops[acc];
      bus0.in_tag      = 4'(8 + acc);
      fire = bus0.in_ready;
      @(posedge clk); #1;
      if (fire) acc++;
    end
    checks++; if (acc !== Depth) begin errors++;
      $display("FAIL stall_accepted got %0d want %0d", acc, Depth); end
    checks++; if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) begin errors++;
      $display("FAIL stall_flags got ready=%0b valid=%0b want 0/1", bus0.in_ready,
               bus0.out_valid); end
    r0 = bus0.out_vector0;
    r1 = bus0.out_vector1;
    rt = bus0.out_tag;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_vector0 !== r0 || bus0.out_vector1 !== r1 ||
          bus0.out_tag !== rt) begin
        errors++;
        $display("FAIL stall_stable got %0h/%0h/%0h want %0h/%0h/%0h", bus0.out_vector0,
                 bus0.out_vector1, bus0.out_tag, r0, r1, rt);
      end
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    for (int j = 0; j < Depth; j++) begin
      #1;
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_tag !== 4'(8 + j) || sum0() !== model0(ops[j]))
      begin
        errors++;
        $display("FAIL stall_drain %0d got v=%0b tag=%0h sum=%0h want 1 %0h %0h", j,
                 bus0.out_valid, bus0.out_tag, sum0(), 8 + j, model0(ops[j]));
      end
      @(posedge clk); #1;
    end
    checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL stall_empty got valid=%0b ready=%0b want 0/1", bus0.out_valid,
               bus0.in_ready); end
  endtask

  task automatic test_wide_random();
    logic [WOw-1:0] q_sum [$];
    logic [3:0]     q_tag [$];
    logic [WOw-1:0] sw;
    logic           in_fire, out_fire;
    for (int c = 0; c < 340; c++) begin
      if (c < 300) begin
        busw.in_valid    = ($urandom_range(0, 3) != 0);
        busw.in_operands = {$urandom, $urandom, $urandom, $urandom};
        busw.in_tag      = 4'($urandom);
        busw.out_ready   = 1'($urandom_range(0, 1));
      end else begin
        busw.in_valid  = 1'b0;
        busw.out_ready = 1'b1;
      end
      #1;
      in_fire  = busw.in_valid && busw.in_ready;
      out_fire = busw.out_valid && busw.out_ready;
      if (out_fire) begin
        sw = busw.out_vector0 + busw.out_vector1;
        checks++;
        if (q_sum.size() == 0) begin
          errors++;
          $display("FAIL wide_spurious got tag=%0h want no result", busw.out_tag);
        end else begin
          if (sw !== q_sum[0] || busw.out_tag !== q_tag[0]) begin
            errors++;
            $display("FAIL wide_result got %0h tag %0h want %0h tag %0h", sw, busw.out_tag,
                     q_sum[0], q_tag[0]);
          end
          void'(q_sum.pop_front());
          void'(q_tag.pop_front());
        end
      end
      if (in_fire) begin
        q_sum.push_back(modelw(busw.in_operands));
        q_tag.push_back(busw.in_tag);
      end
      @(posedge clk); #1;
    end
    checks++; if (q_sum.size() != 0 || busw.out_valid !== 1'b0) begin errors++;
      $display("FAIL wide_leftover got %0d pending valid=%0b want 0/0", q_sum.size(),
               busw.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus0.out_ready   = 1'b0;
    bus0.in_valid    = 1'b1;
    bus0.in_operands = {3{8'h01}};
    bus0.in_tag      = 4'h3;
    @(posedge clk); #1;
    bus0.in_operands = {3{8'hFF}};
    bus0.in_tag      = 4'h4;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_flags got valid=%0b ready=%0b want 0/1", bus0.out_valid,
               bus0.in_ready); end
    checks++;
    if (bus0.out_vector0 !== 12'h0 || bus0.out_vector1 !== 12'h0 || bus0.out_tag !== 4'h0)
    begin
      errors++;
      $display("FAIL midreset_data got %0h/%0h/%0h want 0/0/0", bus0.out_vector0,
               bus0.out_vector1, bus0.out_tag);
    end
    @(negedge clk) rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin errors++;
        $display("FAIL midreset_stale cycle %0d got valid=%0b ready=%0b want 0/1", k,
                 bus0.out_valid, bus0.in_ready); end
    end
  endtask

  initial begin
    bus0.in_valid     = 1'b0;
    bus0.in_operands  = '0;
    bus0.in_tag       = '0;
    bus0.out_ready    = 1'b1;
    bus13.in_valid    = 1'b0;
    bus13.in_operands = '0;
    bus13.in_tag      = '0;
    bus13.out_ready   = 1'b1;
    busw.in_valid     = 1'b0;
    busw.in_operands  = '0;
    busw.in_tag       = '0;
    busw.out_ready    = 1'b1;

    test_reset();
    test_ones();
    test_saturated();
    test_back_to_back();
    test_stall();
    test_wide_random();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dadda_pipe_reducer.md
# dadda_pipe_reducer

Pipelined, parametrised multi-operand reducer. Takes `NumOperands` unsigned partial sums, each weighted by `2^(k*ShiftStep)`, and compresses them with a Dadda-style 3:2 tree into two carry-save vectors. A valid/ready handshake wraps the tree, so it can sit between a partial-product generator and downstream accumulation with full back-pressure at one transaction per cycle. An optional final carry-propagate stage is compiled in by macro.

## Interface
- `InputWidth`, 8, width of each operand
- `NumOperands`, 3, operand count; legal range 2..8
- `ShiftStep`, 2, left shift between consecutive operands in bits
- `OutputWidth`, 12, width of result vectors; results are modulo `2^OutputWidth`
  - Default 12 keeps legacy truncation.
  - `InputWidth+(NumOperands-1)*ShiftStep+clog2(NumOperands)` gives full precision.
- `TagWidth`, 4, width of the sideband tag passed alongside data
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand bundle valid
- `in_ready`  out  1  block can accept this cycle
- `in_operands`  in  `NumOperands*InputWidth`  operand k at `[k*InputWidth +: InputWidth]`
- `in_tag`  in  `TagWidth`  opaque tag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_vector0`, `out_vector1`  out  `OutputWidth`  carry-save pair
- `out_sum`  out  `OutputWidth`  final sum; present only with `DADDA_FINAL_ADD_EN`
- `out_tag`  out  `TagWidth`  tag of the current result

## Operation
- Transfer on either port occurs when valid and ready are both 1 on a rising edge.
- Stage A registers operands and tag on input transfer.
- The reduction tree is combinational from stage A. It registers into stage B as `vector0`/`vector1`, and the tag follows.
- Tree construction: operand k is zero-extended and shifted left by `k*ShiftStep`. Columns are reduced by 3:2 rows (FA where 3 bits, HA where 2) until height ≤ 2. Bits above `OutputWidth-1` are discarded.
- Invariant: `(vector0 + vector1) mod 2^OutputWidth == Σ operand_k·2^(k·ShiftStep) mod 2^OutputWidth`. Bit-exact vector content is free; only the sum is checked.
- Each stage holds a valid flag. A stage loads when it is empty or its contents leave the same cycle.
  - `in_ready = !A_valid || A_advance`
  - `A_advance = !B_valid || B_leave`
  - `B_leave` is the out transfer, or the stage-C advance when the macro is on.
- Stalled stages hold data and tag stable. `out_*` must not change while `out_valid && !out_ready`.
- Simultaneous input and output transfer on a full pipe sustains 1 result/cycle with no bubble.
- `in_valid` low: no stage loads; bubbles propagate.
- Reset asserted mid-operation drops all in-flight transactions and does not emit partial results.

## Timing
- Reset values: all valid flags 0, `out_valid` 0, all data/tag outputs 0, `in_ready` 1 (combinational from empty stage A).
- Latency without macro: input transfer at edge N → `out_valid` high after edge N+1 (2 register stages).
- Latency with macro: `out_valid` after edge N+2.
- Throughput: 1 transaction/cycle while `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`. No combinational path runs from `in_valid` to `out_valid`.
- Stall capacity equals pipeline depth: 2 entries, or 3 with the macro.

## Configuration
- `DADDA_FINAL_ADD_EN`
- Defined: adds stage C, which registers `out_sum = vector0 + vector1` (width `OutputWidth`, carry-out dropped) along with the vectors and tag. `out_sum` port exists. Latency is 3.
- Undefined: no adder, no `out_sum` port. Outputs come directly from stage B. Latency is 2.

## Structure
- Shared package `dadda_pkg`:
  - `clog2` function
  - function returning full-precision output width from (`InputWidth`, `NumOperands`, `ShiftStep`)
  - function returning tree level count for `NumOperands`
  - `MAX_OPERANDS = 8` constant
- Sub-module `csa_row`: parametrised-width word-level 3:2 compressor (bitwise FA). Takes three vectors and returns sum and carry-shifted-left-1. It is instantiated per tree level via generate.

## Test plan
- Default params, operands all `0x01`, `out_ready=1` → after 2 edges `out_valid=1`, `vector0+vector1 = 0x015`. With the macro, `out_sum=0x015` after 3 edges.
- Default params, operands all `0xFF` → sum mod 4096 = `0x4EB` (full value 5355 wraps). With `OutputWidth=13`, sum = `0x14EB`.
- Back-to-back 8 random bundles with tags 0..7, `out_ready=1` → 8 consecutive results in tag order. Each matches the reference model; no bubble.
- Hold `out_ready=0` with `in_valid=1` → exactly 2 accepted (3 with macro), then `in_ready=0`. Outputs stable. Release → in-order drain, nothing lost or duplicated.
- `NumOperands=8`, `ShiftStep=1`, `InputWidth=16`, full-precision width, random stimulus with random `out_ready` → all results exact.
- Assert `rst_n=0` with 2 in flight → `out_valid` and all outputs 0 immediately. After release, `in_ready=1` and no stale result appears.
